// File: rtl/uart_thr_pkg.sv
// uart_thr_pkg: shared constants, FSM state types and frame checksum helper for the UART threshold loader
package uart_thr_pkg;
    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_OPEN  = 8'h01;
    localparam logic [7:0] CMD_CLOSE = 8'h02;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_HDR, GET_CMD, GET_DATA, GET_SUM} prs_state_t;

    function automatic logic [7:0] frame_sum(input logic [7:0] cmd, input logic [7:0] data);
        return HDR_BYTE ^ cmd ^ data;
    endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with a 2-flop rx synchronizer.
// Ports: clk, rst_n (async active-low), rx_i (serial in, idles high),
//        byte_valid_o (1-cycle pulse, good byte), byte_data_o (received byte),
//        byte_err_o (1-cycle pulse, stop bit sampled low).
module uart_rx_byte
    import uart_thr_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, err_q, err_d;
    logic          rx_s, tick;

    assign rx_s = sync_q[1];
    assign tick = cnt_q == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // After a framing error the FSM returns to IDLE, where only a fresh
    // high-to-low edge restarts it, so a held-low line is waited out.
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (prev_q && !rx_s) begin
                state_d = START;
                cnt_d   = HALF_M1;
            end
            START: if (tick) begin
                state_d = rx_s ? IDLE : DATA;
                cnt_d   = FULL_M1;
                bit_d   = '0;
            end
            DATA: if (tick) begin
                data_d  = {rx_s, data_q[7:1]};
                cnt_d   = FULL_M1;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_d = IDLE;
                valid_d = rx_s;
                err_d   = !rx_s;
            end
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;
    assign byte_err_o   = err_q;
endmodule

// File: rtl/uart_threshold_loader.sv
// uart_threshold_loader: loads window-comparator open/close thresholds from UART command frames.
// Ports: clk, rst_n (async active-low), rx (serial in), open_val/close_val (threshold
//        registers), upd (1-cycle pulse on register load), frame_err (1-cycle pulse on reject).
// Macro UART_THR_CHECKSUM_EN: defined -> 4-byte frames A5,cmd,data,sum with sum = A5^cmd^data;
//        undefined -> 3-byte frames A5,cmd,data with no checksum.
module uart_threshold_loader
    import uart_thr_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         TIMEOUT_BITS = 20,
    parameter logic [7:0] OPEN_RST     = 8'hC0,
    parameter logic [7:0] CLOSE_RST    = 8'h40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] open_val,
    output logic [7:0] close_val,
    output logic       upd,
    output logic       frame_err
);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TMO_LIMIT + 1);

    logic       byte_valid, byte_err;
    logic [7:0] byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .byte_err_o   (byte_err)
    );

    prs_state_t    prs_q, prs_d;
    logic [7:0]    cmd_q, cmd_d;
`ifdef UART_THR_CHECKSUM_EN
    logic [7:0]    data_q, data_d;
`endif
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    open_q, open_d, close_q, close_d;
    logic          upd_q, upd_d, err_q, err_d;
    logic          ld;
    logic [7:0]    ld_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prs_q   <= WAIT_HDR;
            cmd_q   <= '0;
`ifdef UART_THR_CHECKSUM_EN
            data_q  <= '0;
`endif
            tmo_q   <= '0;
            open_q  <= OPEN_RST;
            close_q <= CLOSE_RST;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prs_q   <= prs_d;
            cmd_q   <= cmd_d;
`ifdef UART_THR_CHECKSUM_EN
            data_q  <= data_d;
`endif
            tmo_q   <= tmo_d;
            open_q  <= open_d;
            close_q <= close_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    // Loads only ever happen on byte_valid and the timeout only fires without
    // one, so upd and frame_err are mutually exclusive by construction.
    always_comb begin
        prs_d   = prs_q;
        cmd_d   = cmd_q;
`ifdef UART_THR_CHECKSUM_EN
        data_d  = data_q;
`endif
        open_d  = open_q;
        close_d = close_q;
        err_d   = byte_err;
        ld      = 1'b0;
        ld_val  = byte_data;
        if (byte_err) begin
            prs_d = WAIT_HDR;
        end else if (byte_valid) begin
            case (prs_q)
                WAIT_HDR: prs_d = (byte_data == HDR_BYTE) ? GET_CMD : WAIT_HDR;
                GET_CMD: begin
                    cmd_d = byte_data;
                    prs_d = (byte_data == CMD_OPEN || byte_data == CMD_CLOSE) ? GET_DATA : WAIT_HDR;
                    err_d = !(byte_data == CMD_OPEN || byte_data == CMD_CLOSE);
                end
`ifdef UART_THR_CHECKSUM_EN
                GET_DATA: begin
                    data_d = byte_data;
                    prs_d  = GET_SUM;
                end
                GET_SUM: begin
                    prs_d  = WAIT_HDR;
                    ld     = byte_data == frame_sum(cmd_q, data_q);
                    err_d  = !ld;
                    ld_val = data_q;
                end
`else
                GET_DATA: begin
                    prs_d = WAIT_HDR;
                    ld    = 1'b1;
                end
                GET_SUM: prs_d = WAIT_HDR;
`endif
            endcase
        end else if (prs_q != WAIT_HDR && tmo_q == TW'(TMO_LIMIT - 1)) begin
            prs_d = WAIT_HDR;
            err_d = 1'b1;
        end
        upd_d   = ld;
        open_d  = (ld && cmd_q == CMD_OPEN) ? ld_val : open_d;
        close_d = (ld && cmd_q == CMD_CLOSE) ? ld_val : close_d;
        tmo_d   = (prs_d == WAIT_HDR || byte_valid) ? '0 : tmo_q + 1'b1;
    end

    assign open_val  = open_q;
    assign close_val = close_q;
    assign upd       = upd_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_uart_threshold_loader.sv
// tb_uart_threshold_loader: vector table plus randomized frames checked against a frame-level model
module tb_uart_threshold_loader;
    localparam int CPB = 16;
    localparam int TMO = 20;
`ifdef UART_THR_CHECKSUM_EN
    localparam int FLEN = 4;
    localparam logic [7:0] C3 = 8'h30;
    localparam int U3 = 0;
    localparam int E3 = 1;
`else
    localparam int FLEN = 3;
    localparam logic [7:0] C3 = 8'h31;
    localparam int U3 = 1;
    localparam int E3 = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] open_val, close_val;
    logic       upd, frame_err;

    always #5 clk = ~clk;

    uart_threshold_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .open_val  (open_val),
        .close_val (close_val),
        .upd       (upd),
        .frame_err (frame_err)
    );

    int n_cmp = 0, n_bad = 0;
    int n_upd = 0, n_err = 0, ovl = 0, bad_chg = 0;
    logic [7:0] prev_o = 8'hC0, prev_c = 8'h40;

    always @(negedge clk) begin
        if (rst_n) begin
            if (upd) n_upd++;
            if (frame_err) n_err++;
            if (upd && frame_err) ovl++;
            if ((open_val != prev_o || close_val != prev_c) && !upd) bad_chg++;
        end
        prev_o = open_val;
        prev_c = close_val;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(ok, CPB);
        hold(1'b1, CPB);
    endtask

    // Frame-level reference model: accumulated bytes of the current frame
    logic [7:0] m_open = 8'hC0, m_close = 8'h40;
    logic [7:0] fq[$];
    int m_upd = 0, m_err = 0;

    function automatic void m_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_err++;
            fq.delete();
        end else if (fq.size() == 0) begin
            if (b == 8'hA5) fq.push_back(b);
        end else if (fq.size() == 1 && b != 8'h01 && b != 8'h02) begin
            m_err++;
            fq.delete();
        end else begin
            fq.push_back(b);
            if (fq.size() == FLEN) begin
                if (FLEN == 4 && fq[3] != (fq[0] ^ fq[1] ^ fq[2])) m_err++;
                else begin
                    if (fq[1] == 8'h01) m_open = fq[2];
                    else m_close = fq[2];
                    m_upd++;
                end
                fq.delete();
            end
        end
    endfunction

    function automatic void m_gap(input int bits);
        if (bits >= TMO && fq.size() != 0) begin
            m_err++;
            fq.delete();
        end
    endfunction

    typedef struct {
        logic [0:3][7:0] b;
        int              n;
        bit              bad;
        int              gap;
        logic [7:0]      eo;
        logic [7:0]      ec;
        int              eu;
        int              ee;
    } vec_t;

    vec_t tv[8];

    initial begin
        int u0, e0, mu0, me0;
        logic [7:0] hb, cb, db, sb;
        logic [0:3][7:0] fr;
        tv[0] = '{{8'hA5, 8'h01, 8'h80, 8'h24}, 4, 0, 2, 8'h80, 8'h40, 1, 0};
        tv[1] = '{{8'hA5, 8'h02, 8'h30, 8'h97}, 4, 0, 2, 8'h80, 8'h30, 1, 0};
        tv[2] = '{{8'hA5, 8'h02, 8'h31, 8'h00}, 4, 0, 2, 8'h80, C3, U3, E3};
        tv[3] = '{{8'hA5, 8'h07, 8'h10, 8'hB2}, 4, 0, 2, 8'h80, C3, 0, 1};
        tv[4] = '{{8'hA5, 8'h01, 8'h00, 8'h00}, 2, 0, 25, 8'h80, C3, 0, 1};
        tv[5] = '{{8'hA5, 8'h01, 8'h55, 8'hF1}, 4, 0, 2, 8'h55, C3, 1, 0};
        tv[6] = '{{8'h3C, 8'h00, 8'h00, 8'h00}, 1, 1, 2, 8'h55, C3, 0, 1};
        tv[7] = '{{8'hA5, 8'h01, 8'h55, 8'hF1}, 4, 0, 2, 8'h55, C3, 1, 0};

        repeat (5) @(negedge clk);
        check("rst_open", open_val, 8'hC0);
        check("rst_close", close_val, 8'h40);
        rst_n = 1'b1;
        hold(1'b1, 3 * CPB);
        check("rel_open", open_val, 8'hC0);
        check("rel_close", close_val, 8'h40);
        check("rel_upd", n_upd, 0);
        check("rel_err", n_err, 0);

        foreach (tv[k]) begin
            u0 = n_upd;
            e0 = n_err;
            for (int i = 0; i < tv[k].n; i++) begin
                send_byte(tv[k].b[i], !(tv[k].bad && i == tv[k].n - 1));
                m_byte(tv[k].b[i], !(tv[k].bad && i == tv[k].n - 1));
            end
            hold(1'b1, tv[k].gap * CPB);
            m_gap(tv[k].gap + 1);
            check($sformatf("vec%0d_open", k), open_val, tv[k].eo);
            check($sformatf("vec%0d_close", k), close_val, tv[k].ec);
            check($sformatf("vec%0d_upd", k), n_upd - u0, tv[k].eu);
            check($sformatf("vec%0d_err", k), n_err - e0, tv[k].ee);
        end

        u0 = n_upd;
        e0 = n_err;
        hold(1'b0, CPB / 4);
        hold(1'b1, 3 * CPB);
        check("glitch_upd", n_upd - u0, 0);
        check("glitch_err", n_err - e0, 0);
        check("glitch_open", open_val, 8'h55);

        send_byte(8'hA5, 1);
        send_byte(8'h02, 1);
        send_byte(8'h77, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_open", open_val, 8'hC0);
        check("midrst_close", close_val, 8'h40);
        check("midrst_upd", upd, 1'b0);
        rst_n = 1'b1;
        m_open = 8'hC0;
        m_close = 8'h40;
        fq.delete();
        u0 = n_upd;
        e0 = n_err;
        send_byte(8'h77 ^ 8'hA7, 1);
        hold(1'b1, 2 * CPB);
        check("postrst_close", close_val, 8'h40);
        check("postrst_upd", n_upd - u0, 0);
        check("postrst_err", n_err - e0, 0);

        for (int f = 0; f < 30; f++) begin
            u0 = n_upd;
            e0 = n_err;
            mu0 = m_upd;
            me0 = m_err;
            if ($urandom_range(7) == 0) begin
                hold(1'b1, 25 * CPB);
                m_gap(25);
            end
            hb = ($urandom_range(5) != 0) ? 8'hA5 : 8'($urandom);
            cb = ($urandom_range(3) == 0) ? 8'($urandom) : ($urandom_range(1) ? 8'h01 : 8'h02);
            db = 8'($urandom);
            sb = ($urandom_range(3) != 0) ? (hb ^ cb ^ db) : 8'($urandom);
            fr = {hb, cb, db, sb};
            for (int i = 0; i < 4; i++) begin
                bit ok;
                ok = $urandom_range(11) != 0;
                send_byte(fr[i], ok);
                m_byte(fr[i], ok);
                hold(1'b1, $urandom_range(2) * CPB);
            end
            check($sformatf("rnd%0d_open", f), open_val, m_open);
            check($sformatf("rnd%0d_close", f), close_val, m_close);
            check($sformatf("rnd%0d_upd", f), n_upd - u0, m_upd - mu0);
            check($sformatf("rnd%0d_err", f), n_err - e0, m_err - me0);
        end

        check("pulse_overlap", ovl, 0);
        check("change_without_upd", bad_chg, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_threshold_loader.md
Name: uart_threshold_loader

Overview:
- Upstream stage of the 8-bit window comparator. It loads that comparator's `open` and `close` threshold bytes from a host over an 8N1 UART line.
- Receives serial bytes and parses fixed command frames.
- Updates the two threshold registers atomically per frame.
- The registers drive the comparator's threshold inputs directly and hold their value between updates.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 8.
- TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one frame before the parser aborts.
- OPEN_RST, 8'hC0, reset value of open_val.
- CLOSE_RST, 8'h40, reset value of close_val.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  UART serial input; idles high
- open_val  out  8  open threshold to the comparator
- close_val  out  8  close threshold to the comparator
- upd  out  1  one-cycle pulse when a threshold register changes
- frame_err  out  1  one-cycle pulse when a frame or byte is rejected

Behaviour:
- Reset (async assert, sync release):
  - open_val=OPEN_RST, close_val=CLOSE_RST, upd=0, frame_err=0.
  - Both FSMs go to idle; the bit counter and the timeout counter clear to 0.
  - A reset asserted mid-frame discards the partial frame; the registers return to reset values.
- rx passes through a 2-flop synchronizer, preset to 1 on reset. All rx references below use the synchronized signal.
- Byte receiver FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a high-to-low edge enters START and loads the bit counter.
  - START: re-samples at CLKS_PER_BIT/2. If rx is high, the edge is a glitch: return to IDLE silently.
  - DATA: samples 8 bits, LSB first, each CLKS_PER_BIT after the previous sample.
  - STOP: samples the stop bit. High means byte_valid is pulsed for 1 cycle. Low means a framing error: frame_err pulses, the byte is dropped, and the FSM waits for rx high before returning to IDLE.
- Frame parser FSM: WAIT_HDR -> GET_CMD -> GET_DATA -> GET_SUM -> WAIT_HDR.
  - WAIT_HDR: any byte other than 8'hA5 is ignored with no error.
  - GET_CMD: 8'h01 selects open and 8'h02 selects close. Any other value, including 8'hA5, pulses frame_err and returns to WAIT_HDR.
  - GET_DATA: latches the data byte.
  - GET_SUM: expected byte = 8'hA5 ^ cmd ^ data.
    - On match, the selected register takes the data byte and upd pulses in the same cycle the register changes. Latency is 1 clk after the stop-bit sample of the checksum byte.
    - On mismatch, frame_err pulses and no register changes.
- Inter-byte timeout:
  - In any parser state other than WAIT_HDR, the counter runs while no byte completes.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT cycles pulses frame_err and returns the parser to WAIT_HDR.
  - The counter clears on every byte_valid.
- Loading a value equal to the current register still pulses upd.
- open_val == close_val is accepted without checking; resolving it is the comparator's concern.
- A receiver framing error inside a frame also aborts the parser to WAIT_HDR.
- upd and frame_err never pulse in the same cycle.

Optional Feature:
- Macro UART_THR_CHECKSUM_EN.
- Defined: 4-byte frames with the GET_SUM check exactly as above.
- Undefined:
  - Frames are 3 bytes (header, cmd, data) and the GET_SUM state is omitted.
  - The register updates and upd pulses 1 clk after the data byte's stop-bit sample.
  - The checksum-mismatch error source does not exist.

Decomposition:
- Package uart_thr_pkg holds:
  - constants HDR_BYTE=8'hA5, CMD_OPEN=8'h01, CMD_CLOSE=8'h02;
  - rx_state_t {IDLE, START, DATA, STOP};
  - prs_state_t {WAIT_HDR, GET_CMD, GET_DATA, GET_SUM}.
- One sub-module, uart_rx_byte, contains the synchronizer and the byte FSM. It outputs byte_valid, byte_data[7:0] and byte_err.
- The parser, the registers and the timeout logic stay in the top level.

Test Plan:
- Reset release → open_val=8'hC0, close_val=8'h40, no pulses.
- Send A5 01 80 24 → open_val=8'h80 with a single upd pulse; close_val remains 8'h40.
- Send A5 02 30 97 → close_val=8'h30, upd once. Then send A5 02 31 00 (bad checksum) → frame_err once, close_val stays 8'h30.
- Send A5 07 10 B2 → frame_err at the cmd byte. The next bytes 10 and B2 are ignored in WAIT_HDR, and both registers are unchanged.
- Send A5 01, then hold rx high for 25 bit-times → frame_err from the timeout. A following valid frame A5 01 55 F1 loads open_val=8'h55.
- Send byte 0x3C with its stop bit low → frame_err, no upd. Separately, a 0.25-bit low glitch on idle rx → no byte, no pulses.
